cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Clock-enable scheduler for the pipelined CPU core. It runs in the single-ended 100 MHz domain produced by the differential-clock front end and generates one `cpu_ce` qualifier per CPU advance. Four modes are supported: halt, full-speed run, divided run and debounced single-step. An optional PC breakpoint stops the core, so the board can be debugged at human speed without touching the clock tree.

## Interface
- `DIV_W`, 24: width of divider reload value.
- `DEB_CYCLES`, 1000000: cycles the step button must be stable (10 ms at 100 MHz).
- `PC_W`, 32: width of PC compare.

- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode` in 2: 00 halt, 01 run full, 10 run divided, 11 single-step.
- `div_val` in DIV_W: divided-run period minus one.
- `step_btn` in 1: raw asynchronous push-button, active-high.
- `pc` in PC_W: PC of the instruction the next `cpu_ce` would execute.
- `brk_addr` in PC_W: breakpoint address.
- `brk_en` in 1: breakpoint armed.
- `brk_clr` in 1: single-cycle pulse that leaves breakpoint-halt.
- `cpu_ce` out 1: registered CPU clock enable; one pulse is one CPU cycle.
- `halted` out 1: high when no `cpu_ce` is being scheduled (HALT, STEP idle, BRK).
- `brk_hit` out 1: high while in BRK.
- `ce_cnt` out 32: count of issued `cpu_ce` pulses; wraps 2^32-1 to 0.

## Operation
- **Reset values:** state HALT, `cpu_ce`=0, `halted`=1, `brk_hit`=0, `ce_cnt`=0, divider counter 0, debounce counter 0, synchronizers 0.
- **State machine:** HALT, RUN, STEP, BRK.
  - HALT to RUN when `mode` is 01 or 10.
  - HALT to STEP when `mode`=11.
  - RUN or STEP to HALT when `mode`=00.
  - RUN and STEP cross directly on a `mode` change.
  - RUN to BRK on a breakpoint hit.
  - BRK to the state selected by `mode` when `brk_clr`=1. The first `cpu_ce` after leaving BRK is exempt from the breakpoint compare.
  - BRK ignores `mode` until `brk_clr` arrives.
- **Full run:** `cpu_ce`=1 every cycle.
- **Divided run:**
  - The divider counts 0..`div_val`; `cpu_ce` pulses on the cycle where the count equals `div_val`, then the count reloads 0.
  - `div_val`=0 is identical to full run.
  - A new `div_val` below the current count forces a wrap on the next cycle.
  - Any `mode` change clears the divider.
- **Single-step:**
  - `step_btn` passes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized input has differed from it for `DEB_CYCLES` consecutive cycles.
  - Each debounced rising edge in STEP produces exactly one `cpu_ce` pulse. Holding the button produces no further pulses.
  - Edges occurring in other states are discarded, not queued.
  - The breakpoint is not checked in STEP.
- **Breakpoint:** in RUN, when a `cpu_ce` would be issued and `brk_en`=1 and `pc`==`brk_addr`:
  - that `cpu_ce` is suppressed;
  - state goes to BRK;
  - the instruction at `brk_addr` is not executed.
- **`ce_cnt`:** increments on every cycle `cpu_ce` is 1.

## Timing
- `cpu_ce` is registered. The first pulse appears 1 cycle after `mode` changes from 00 to 01 (count the pulse in the cycle after the edge where `mode` is sampled).
- In divided run, successive `cpu_ce` pulses are exactly `div_val`+1 cycles apart.
- From step button press to `cpu_ce`: 2 (sync) + `DEB_CYCLES` + 1 cycles.
- Breakpoint: `brk_hit` rises in the cycle the suppressed `cpu_ce` would have appeared; `halted` rises with it.
- `brk_clr` and `mode` changing in the same cycle: `brk_clr` is evaluated against the new `mode`.
- Asserting `rst_n` low mid-run clears `cpu_ce` immediately (asynchronous); no partial pulse is emitted on release.

## Configuration
- `CPU_CLK_CTRL_BRK_EN`
  - **Defined:** breakpoint logic, BRK state and `brk_hit` behave as above.
  - **Undefined:**
    - ports `brk_addr`, `brk_en` and `brk_clr` remain but are ignored;
    - `brk_hit` is tied 0;
    - BRK is unreachable;
    - no PC comparator is synthesized.

## Test plan
- **Reset:** hold `rst_n`=0 with `mode`=01 → `cpu_ce`=0, `halted`=1, `ce_cnt`=0. Release → `cpu_ce`=1 from the 2nd cycle and `ce_cnt`=10 after 10 pulses.
- **Divided run:** `mode`=10, `div_val`=3 for 40 cycles → 10 pulses spaced 4 cycles. Change `div_val` to 0 mid-count → `cpu_ce` every cycle after one wrap.
- **Single-step:** `DEB_CYCLES`=16, `mode`=11.
  - Press with 5 bounces of 3 cycles, then hold 100 cycles → exactly one `cpu_ce`, 19 cycles after the stable edge.
  - Release and press again → second pulse, `ce_cnt`=2.
- **Breakpoint:** `brk_en`=1, `brk_addr`=0x0000_0010, `pc` stepping by 4 from 0 on each `cpu_ce` → 4 pulses, then `brk_hit`=1 with `pc`=0x10 unexecuted. `brk_clr` → next pulse executes 0x10 and is not re-trapped.
- **Mode switch:** mode switch 01→00 mid-run → `cpu_ce`=0 next cycle, `halted`=1. Step-button edges while in HALT → no pulse after switching to 11.
- **Build without `CPU_CLK_CTRL_BRK_EN`:** rerun the breakpoint scenario → `brk_hit` stays 0 and pulses continue past 0x10.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: CPU clock-enable scheduler (halt / full run / divided run / debounced single-step).
// Optional PC breakpoint is built when CPU_CLK_CTRL_BRK_EN is defined.
module cpu_clk_ctrl #(
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step_btn,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  brk_addr,
  input  logic             brk_en,
  input  logic             brk_clr,
  output logic             cpu_ce,
  output logic             halted,
  output logic             brk_hit,
  output logic [31:0]      ce_cnt
);

  localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {HALT, RUN, STEP, BRK} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_d;
  logic             exempt_q, exempt_d;
  logic             ce_d;
  logic             issue;
  logic             pc_match;
  logic             clr_req;

  logic             step_s1, step_s2, step_deb, step_deb_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             step_rise;

  // Step button: 2-FF synchronizer, then a level that flips only after
  // DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_s1    <= 1'b0;
      step_s2    <= 1'b0;
      step_deb   <= 1'b0;
      step_deb_q <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      step_s1    <= step_btn;
      step_s2    <= step_s1;
      step_deb_q <= step_deb;
      if (step_s2 == step_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        step_deb <= step_s2;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  assign step_rise = step_deb & ~step_deb_q;

`ifdef CPU_CLK_CTRL_BRK_EN
  assign pc_match = brk_en && (pc == brk_addr);
  assign clr_req  = brk_clr;
  assign brk_hit  = (state_q == BRK);
`else
  logic unused_brk_ports;
  assign unused_brk_ports = ^{pc, brk_addr, brk_en, brk_clr};
  assign pc_match = 1'b0;
  assign clr_req  = 1'b0;
  assign brk_hit  = 1'b0;
`endif

  function automatic state_t mode_target(input logic [1:0] m);
    case (m)
      MODE_HALT: return HALT;
      MODE_STEP: return STEP;
      default:   return RUN;
    endcase
  endfunction

  // cpu_ce is decided against the state being entered, so a mode change
  // yields its first pulse on the same edge that samples it.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d  = state_q;
    ce_d     = 1'b0;
    div_d    = '0;
    exempt_d = exempt_q;
    issue    = 1'b0;

    case (state_q)
      BRK: begin
        if (clr_req) begin
          state_d  = mode_target(mode);
          exempt_d = 1'b1;
        end
      end
      default: state_d = mode_target(mode);
    endcase

    if (state_d == RUN) begin
      issue = 1'b1;
      if (mode == MODE_DIV && div_cnt_q < div_val) begin
        issue = 1'b0;
        div_d = div_cnt_q + DIV_ONE;
      end
      if (issue && pc_match && !exempt_d) begin
        state_d = BRK;
      end else begin
        ce_d = issue;
      end
    end else if (state_d == STEP) begin
      ce_d = step_rise;
    end

    if (ce_d) begin
      exempt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HALT;
      cpu_ce    <= 1'b0;
      div_cnt_q <= '0;
      exempt_q  <= 1'b0;
      ce_cnt    <= '0;
    end else begin
      state_q   <= state_d;
      cpu_ce    <= ce_d;
      div_cnt_q <= div_d;
      exempt_q  <= exempt_d;
      if (ce_d) begin
        ce_cnt <= ce_cnt + 32'd1;
      end
    end
  end

  assign halted = (state_q != RUN) && !cpu_ce;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios plus a randomized run,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_cpu_clk_ctrl;

  localparam int DEB = 16;
`ifdef CPU_CLK_CTRL_BRK_EN
  localparam bit BRK_FEAT = 1'b1;
`else
  localparam bit BRK_FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  div_val;
  logic        step_btn;
  logic [31:0] pc;
  logic [31:0] brk_addr;
  logic        brk_en;
  logic        brk_clr;
  logic        cpu_ce;
  logic        halted;
  logic        brk_hit;
  logic [31:0] ce_cnt;

  cpu_clk_ctrl #(.DIV_W(8), .DEB_CYCLES(DEB), .PC_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .div_val  (div_val),
    .step_btn (step_btn),
    .pc       (pc),
    .brk_addr (brk_addr),
    .brk_en   (brk_en),
    .brk_clr  (brk_clr),
    .cpu_ce   (cpu_ce),
    .halted   (halted),
    .brk_hit  (brk_hit),
    .ce_cnt   (ce_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cpu_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_HALT, M_RUN, M_STEP, M_BRK} m_state_e;
  m_state_e    m_st;
  bit          m_ce;
  int unsigned m_cnt;
  int          m_age;      // divided-run cycles since entry or since last pulse
  bit          m_was_div;
  bit          m_ex;       // next pulse skips the breakpoint compare
  bit          m_lvl, m_lvl_prev;
  int          m_run;      // consecutive synchronized samples disagreeing with m_lvl
  bit          raw_q[$];   // raw button samples, one per clock edge

  task automatic model_reset();
    m_st = M_HALT; m_ce = 0; m_cnt = 0; m_age = 0; m_was_div = 0; m_ex = 0;
    m_lvl = 0; m_lvl_prev = 0; m_run = 0; raw_q.delete();
  endtask

  task automatic model_step();
    bit sync_now, rise, want, ex;
    m_state_e dest;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // synchronizer output at this edge is the raw sample from two edges ago
    sync_now = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
    raw_q.push_back(step_btn);
    if (raw_q.size() > 4) void'(raw_q.pop_front());
    rise = m_lvl && !m_lvl_prev;
    m_lvl_prev = m_lvl;
    if (sync_now != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin m_lvl = sync_now; m_run = 0; end
    end else begin
      m_run = 0;
    end

    ex   = m_ex;
    dest = (mode == 2'b00) ? M_HALT : (mode == 2'b11) ? M_STEP : M_RUN;
    if (m_st == M_BRK) begin
      if (BRK_FEAT && brk_clr) ex = 1;
      else dest = M_BRK;
    end
    m_ce = 0;
    if (dest == M_RUN) begin
      if (mode == 2'b10) begin
        if (!m_was_div) m_age = 0;
        want  = (m_age >= int'(div_val));
        m_age = want ? 0 : m_age + 1;
      end else begin
        want = 1;
      end
      if (want && BRK_FEAT && brk_en && pc == brk_addr && !ex) dest = M_BRK;
      else m_ce = want;
    end else if (dest == M_STEP) begin
      m_ce = rise;
    end
    m_was_div = (dest == M_RUN && mode == 2'b10);
    if (m_ce) begin ex = 0; m_cnt++; end
    m_ex = ex;
    m_st = dest;
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge,
  // then the CPU stand-in moves pc on to the next instruction.
  task automatic tick();
    bit exp_halted;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_halted = (m_st == M_HALT) || (m_st == M_BRK) || (m_st == M_STEP && !m_ce);
    check("cpu_ce",  32'(cpu_ce),  32'(m_ce));
    check("halted",  32'(halted),  32'(exp_halted));
    check("brk_hit", 32'(brk_hit), 32'(m_st == M_BRK));
    check("ce_cnt",  ce_cnt,       m_cnt);
    if (cpu_ce) begin
      cpu_pulses++;
      pc = 32'((cpu_pulses * 4) & 255);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    cpu_pulses = 0;
    pc = 32'h0;
  endtask

  initial begin
    int n, last, lat, hits;
    rst_n = 1'b0; mode = 2'b01; div_val = 8'd0; step_btn = 1'b0;
    pc = 32'h0; brk_addr = 32'h0; brk_en = 1'b0; brk_clr = 1'b0;
    model_reset();

    // reset held with mode = full run
    repeat (3) tick();
    check("rst_ce", 32'(cpu_ce), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_cnt", ce_cnt, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 10; i++) begin
      tick();
      if (cpu_ce) n++;
    end
    check("run_pulses", n, 10);
    check("run_cnt10", ce_cnt, 10);

    // full run -> halt
    mode = 2'b00;
    tick();
    check("halt_ce", 32'(cpu_ce), 0);
    check("halt_halted", 32'(halted), 1);

    // divided run, div_val = 3
    mode = 2'b10; div_val = 8'd3; n = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_ce) begin
        if (last >= 0) check("div_gap", i - last, 4);
        last = i;
        n++;
      end
    end
    check("div_pulses", n, 10);
    for (int i = 0; i < 8 && !cpu_ce; i++) tick();
    tick(); tick();
    div_val = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("div0_ce", 32'(cpu_ce), 1);
    end

    // async reset mid-run clears cpu_ce without waiting for a clock
    mode = 2'b01;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_ce", 32'(cpu_ce), 0);
    check("async_cnt", ce_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    cpu_pulses = 0; pc = 32'h0;
    repeat (4) tick();

    // single-step with a bouncing press
    do_reset();
    mode = 2'b11;
    for (int b = 0; b < 5; b++) begin
      step_btn = 1'b1; repeat (3) tick();
      step_btn = 1'b0; repeat (3) tick();
    end
    step_btn = 1'b1; n = 0; lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (cpu_ce) begin
        n++;
        if (lat < 0) lat = i;
      end
    end
    check("step_pulses", n, 1);
    check("step_lat", lat, 19);
    step_btn = 1'b0; repeat (30) tick();
    step_btn = 1'b1; repeat (30) tick();
    check("step_cnt2", ce_cnt, 2);

    // button edges while halted are discarded
    mode = 2'b00;
    step_btn = 1'b0; repeat (30) tick();
    step_btn = 1'b1; repeat (30) tick();
    mode = 2'b11; n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce) n++;
    end
    check("halt_edge_pulses", n, 0);
    step_btn = 1'b0;

    // breakpoint at 0x10 with pc advancing by 4 per pulse
    do_reset();
    brk_en = 1'b1; brk_addr = 32'h10; mode = 2'b01;
    for (int i = 0; i < 20 && !brk_hit; i++) tick();
`ifdef CPU_CLK_CTRL_BRK_EN
    check("brk_pulses", cpu_pulses, 4);
    check("brk_hit_set", 32'(brk_hit), 1);
    check("brk_pc", pc, 32'h10);
    mode = 2'b00;
    repeat (3) tick();
    check("brk_holds", 32'(brk_hit), 1);
    mode = 2'b01; brk_clr = 1'b1;
    tick();
    brk_clr = 1'b0;
    check("brk_resume_ce", 32'(cpu_ce), 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (brk_hit) hits++;
    end
    check("brk_no_retrap", hits, 0);
`else
    check("nobrk_hit", 32'(brk_hit), 0);
    check("nobrk_pulses", cpu_pulses, 20);
    check("nobrk_pc_past", 32'(pc > 32'h10), 1);
`endif

    // randomized traffic against the model
    do_reset();
    brk_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) div_val = 8'($urandom_range(5));
      if ($urandom_range(39) == 0) step_btn = ~step_btn;
      brk_clr = ($urandom_range(24) == 0);
      if ($urandom_range(99) == 0) begin
        brk_en   = 1'($urandom_range(1));
        brk_addr = 32'($urandom_range(63)) << 2;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
